// File: rtl/nabp_pkg.sv
// Shared types and constants for the NABP shifter handshake blocks.
//   seq_state_t    : states of the shift sequencer FSM
//   DEFAULT_ACCU_W : accumulator step width, common to sequencer and shifter
package nabp_pkg;

  localparam int unsigned DEFAULT_ACCU_W = 16;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR       = 4'd1,
    DATA       = 4'd2,
    FILL_KICK  = 4'd3,
    FILL_WAIT  = 4'd4,
    SHIFT_ARM  = 4'd5,
    SHIFT_KICK = 4'd6,
    SHIFT_WAIT = 4'd7,
    FIN        = 4'd8
  } seq_state_t;

endpackage

// File: rtl/nabp_shift_sequencer.sv
// Initiator side of the shifter fill/shift handshake. Walks projection angles
// 0..NUM_ANGLES-1; for each angle it reads the accumulator step from the angle
// ROM, kicks the fill phase, waits fill_done, waits for PE readiness, kicks
// the shift phase and waits shift_done.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start              1-cycle frame start request (ignored while busy)
//   busy / done        frame in progress / 1-cycle end-of-frame pulse
//   err                sticky protocol error (stray done pulse)
//   angle_idx          current angle, valid while busy
//   rom_addr/rom_data  angle ROM port, data valid 1 cycle after address
//   sh_fill_kick       1-cycle fill phase start
//   sh_shift_kick      1-cycle shift phase start
//   sh_accu_base       per-angle step, stable from fill kick through shift_done
//   sh_fill_done       1-cycle pulse from shifter
//   sh_shift_done      1-cycle pulse from shifter
//   pe_ready           PE array may accept a new shift phase
module nabp_shift_sequencer
  import nabp_pkg::*;
#(
  parameter int unsigned NUM_ANGLES = 180,
  parameter int unsigned ANGLE_W    = 8,
  parameter int unsigned ACCU_W     = DEFAULT_ACCU_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ANGLE_W-1:0] angle_idx,
  output logic [ANGLE_W-1:0] rom_addr,
  input  logic [ACCU_W-1:0]  rom_data,
  output logic               sh_fill_kick,
  output logic               sh_shift_kick,
  output logic [ACCU_W-1:0]  sh_accu_base,
  input  logic               sh_fill_done,
  input  logic               sh_shift_done,
  input  logic               pe_ready
);

  localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(NUM_ANGLES - 1);

  seq_state_t          state_q, state_d;
  logic [ANGLE_W-1:0]  angle_d;
  logic [ACCU_W-1:0]   base_d;
  logic                err_d;
  logic                busy_d;
  logic                done_d;
  logic                fill_kick_d;
  logic                shift_kick_d;
  logic                stray_done;

  // Next state, counter, base register and error flag; outputs are decoded
  // from the next state so every output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    angle_d      = angle_idx;
    base_d       = sh_accu_base;
    err_d        = err;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    fill_kick_d  = 1'b0;
    shift_kick_d = 1'b0;

    // A done pulse that does not match the waiting state is dropped and flagged.
    stray_done = (sh_fill_done  && (state_q != FILL_WAIT)) ||
                 (sh_shift_done && (state_q != SHIFT_WAIT));
    if (stray_done) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR;
          angle_d = '0;
          err_d   = stray_done;
        end
      end
      ADDR:       state_d = DATA;
      DATA: begin
        base_d  = rom_data;
        state_d = FILL_KICK;
      end
      FILL_KICK:  state_d = FILL_WAIT;
      FILL_WAIT:  if (sh_fill_done) state_d = SHIFT_ARM;
      SHIFT_ARM:  if (pe_ready) state_d = SHIFT_KICK;
      SHIFT_KICK: state_d = SHIFT_WAIT;
      SHIFT_WAIT: begin
        if (sh_shift_done) begin
          if (angle_idx == LAST_ANGLE) begin
            state_d = FIN;
          end else begin
            angle_d = angle_idx + ANGLE_W'(1);
            state_d = ADDR;
          end
        end
      end
      FIN:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
    fill_kick_d  = (state_d == FILL_KICK);
    shift_kick_d = (state_d == SHIFT_KICK);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      angle_idx     <= '0;
      sh_accu_base  <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sh_fill_kick  <= 1'b0;
      sh_shift_kick <= 1'b0;
    end else begin
      state_q       <= state_d;
      angle_idx     <= angle_d;
      sh_accu_base  <= base_d;
      err           <= err_d;
      busy          <= busy_d;
      done          <= done_d;
      sh_fill_kick  <= fill_kick_d;
      sh_shift_kick <= shift_kick_d;
    end
  end

  // The ROM is addressed by the registered angle counter directly.
  assign rom_addr = angle_idx;

endmodule

// File: tb/tb_nabp_shift_sequencer.sv
// Bench for nabp_shift_sequencer: a 4-angle instance driven through frame
// scenarios with a per-kick scoreboard, plus a 1-angle instance.
module tb_nabp_shift_sequencer;

  localparam int unsigned NA = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, sh_fill_done, sh_shift_done, pe_ready;
  logic          busy, done, err, sh_fill_kick, sh_shift_kick;
  logic [AW-1:0] angle_idx, rom_addr;
  logic [DW-1:0] rom_data, sh_accu_base;

  logic          start_1, fill_done_1, shift_done_1, pe_ready_1;
  logic          busy_1, done_1, err_1, fill_kick_1, shift_kick_1;
  logic [0:0]    angle_idx_1, rom_addr_1;
  logic [DW-1:0] rom_data_1, accu_base_1;

  nabp_shift_sequencer #(.NUM_ANGLES(NA), .ANGLE_W(AW), .ACCU_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .err(err), .angle_idx(angle_idx), .rom_addr(rom_addr), .rom_data(rom_data),
    .sh_fill_kick(sh_fill_kick), .sh_shift_kick(sh_shift_kick),
    .sh_accu_base(sh_accu_base), .sh_fill_done(sh_fill_done),
    .sh_shift_done(sh_shift_done), .pe_ready(pe_ready)
  );

  nabp_shift_sequencer #(.NUM_ANGLES(1), .ANGLE_W(1), .ACCU_W(DW)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_1), .busy(busy_1), .done(done_1),
    .err(err_1), .angle_idx(angle_idx_1), .rom_addr(rom_addr_1), .rom_data(rom_data_1),
    .sh_fill_kick(fill_kick_1), .sh_shift_kick(shift_kick_1),
    .sh_accu_base(accu_base_1), .sh_fill_done(fill_done_1),
    .sh_shift_done(shift_done_1), .pe_ready(pe_ready_1)
  );

  // Angle ROM models: data = 0x1000 * (idx + 1), one cycle after the address.
  always @(posedge clk) begin
    rom_data   <= (16'(rom_addr) + 16'd1) << 12;
    rom_data_1 <= (16'(rom_addr_1) + 16'd1) << 12;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] base;
  } exp_t;
  exp_t exp_q[$];

  int fill_cnt = 0, shift_cnt = 0, done_cnt = 0;
  int fill_cnt_1 = 0, shift_cnt_1 = 0;
  bit prev_fill = 1'b0, prev_shift = 1'b0, in_phase = 1'b0;
  logic [DW-1:0] base_lat = '0;

  // Scoreboard and running protocol checks on the 4-angle instance.
  always @(negedge clk) begin
    if (busy !== 1'b1) in_phase = 1'b0;
    n_checks++;
    if (sh_fill_kick === 1'b1 && sh_shift_kick === 1'b1) begin
      n_fail++; $display("FAIL kick_overlap: both kicks high at %0t", $time);
    end
    n_checks++;
    if ((sh_fill_kick === 1'b1 && prev_fill) || (sh_shift_kick === 1'b1 && prev_shift)) begin
      n_fail++; $display("FAIL kick_width: kick high two cycles at %0t", $time);
    end
    n_checks++;
    if ((sh_fill_kick === 1'b1 || sh_shift_kick === 1'b1) && (busy !== 1'b1 || done === 1'b1)) begin
      n_fail++; $display("FAIL kick_in_idle_fin: busy=%0b done=%0b at %0t", busy, done, $time);
    end
    if (sh_fill_kick === 1'b1) begin
      fill_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL fill_kick_unexpected: idx=%0d at %0t", angle_idx, $time);
      end else if (angle_idx !== exp_q[0].idx || sh_accu_base !== exp_q[0].base) begin
        n_fail++;
        $display("FAIL fill_kick_data: got idx=%0d base=%h, expected idx=%0d base=%h",
                 angle_idx, sh_accu_base, exp_q[0].idx, exp_q[0].base);
      end
      base_lat = sh_accu_base;
      in_phase = 1'b1;
    end else if (in_phase) begin
      n_checks++;
      if (sh_accu_base !== base_lat) begin
        n_fail++; $display("FAIL accu_base_stable: got %h expected %h", sh_accu_base, base_lat);
      end
    end
    if (sh_shift_kick === 1'b1) begin
      shift_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL shift_kick_unexpected: idx=%0d at %0t", angle_idx, $time);
      end else begin
        if (angle_idx !== exp_q[0].idx || sh_accu_base !== exp_q[0].base) begin
          n_fail++;
          $display("FAIL shift_kick_data: got idx=%0d base=%h, expected idx=%0d base=%h",
                   angle_idx, sh_accu_base, exp_q[0].idx, exp_q[0].base);
        end
        void'(exp_q.pop_front());
      end
    end
    if (done === 1'b1) done_cnt++;
    if (fill_kick_1 === 1'b1) fill_cnt_1++;
    if (shift_kick_1 === 1'b1) shift_cnt_1++;
    prev_fill  = (sh_fill_kick === 1'b1);
    prev_shift = (sh_shift_kick === 1'b1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < int'(NA); i++) begin
      e.idx  = AW'(i);
      e.base = DW'((i + 1) * 4096);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_fill(output int cyc);
    cyc = 0;
    while (sh_fill_kick !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    if (cyc >= 100) cyc = -1;
  endtask

  task automatic wait_shift(output int cyc);
    cyc = 0;
    while (sh_shift_kick !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    if (cyc >= 100) cyc = -1;
  endtask

  // Shifter model for one angle: fill_done 5 cycles after fill kick,
  // shift_done 8 cycles after shift kick, with optional disturbances.
  task automatic serve_angle(input int idx, input int pe_hold, input bit spur,
                             input bit glitch, input bit last);
    int cyc;
    wait_fill(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL fill_kick_latency: angle %0d got %0d expected 2", idx, cyc);
    end
    if (spur) begin
      tick(2);
      sh_shift_done = 1'b1; tick(); sh_shift_done = 1'b0;
      n_checks++;
      if (err !== 1'b1) begin
        n_fail++; $display("FAIL err_on_spurious: got %0b expected 1", err);
      end
      tick(2);
    end else begin
      tick(5);
    end
    if (pe_hold > 0) pe_ready = 1'b0;
    sh_fill_done = 1'b1; tick(); sh_fill_done = 1'b0;
    if (pe_hold > 0) begin
      repeat (pe_hold) begin
        n_checks++;
        if (sh_shift_kick !== 1'b0) begin
          n_fail++; $display("FAIL shift_kick_withheld: got %0b expected 0", sh_shift_kick);
        end
        tick();
      end
      n_checks++;
      if (angle_idx !== AW'(idx)) begin
        n_fail++; $display("FAIL angle_hold: got %0d expected %0d", angle_idx, idx);
      end
      pe_ready = 1'b1; tick();
      n_checks++;
      if (sh_shift_kick !== 1'b1) begin
        n_fail++; $display("FAIL shift_kick_after_pe_ready: got %0b expected 1", sh_shift_kick);
      end
    end else begin
      wait_shift(cyc);
      n_checks++;
      if (cyc !== 1) begin
        n_fail++; $display("FAIL shift_kick_latency: angle %0d got %0d expected 1", idx, cyc);
      end
    end
    if (glitch) begin
      tick(3); start = 1'b1; tick(); start = 1'b0; tick(4);
    end else begin
      tick(8);
    end
    sh_shift_done = 1'b1; tick(); sh_shift_done = 1'b0;
    n_checks++;
    if (done !== last) begin
      n_fail++; $display("FAIL done_after_shift_done: angle %0d got %0b expected %0b", idx, done, last);
    end
    if (last) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL frame_end_idle: got done=%0b busy=%0b expected 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(3);
    n_checks++;
    if ({busy, done, err, sh_fill_kick, sh_shift_kick} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                         {busy, done, err, sh_fill_kick, sh_shift_kick});
    end
    n_checks++;
    if (angle_idx !== '0 || rom_addr !== '0 || sh_accu_base !== '0) begin
      n_fail++; $display("FAIL reset_values: got idx=%0d addr=%0d base=%h expected 0 0 0",
                         angle_idx, rom_addr, sh_accu_base);
    end
    reset_n = 1'b1; tick();
  endtask

  task automatic test_nominal();
    int f0 = fill_cnt, s0 = shift_cnt, d0 = done_cnt;
    push_frame(); start_frame();
    n_checks++;
    if (busy !== 1'b1 || angle_idx !== '0) begin
      n_fail++; $display("FAIL busy_after_start: got busy=%0b idx=%0d expected 1 0", busy, angle_idx);
    end
    for (int i = 0; i < int'(NA); i++) serve_angle(i, 0, 1'b0, 1'b0, i == int'(NA) - 1);
    n_checks++;
    if (fill_cnt - f0 !== 4 || shift_cnt - s0 !== 4 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL nominal_counts: got fill=%0d shift=%0d done=%0d expected 4 4 1",
                         fill_cnt - f0, shift_cnt - s0, done_cnt - d0);
    end
    n_checks++;
    if (err !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL nominal_err: got err=%0b pending=%0d expected 0 0", err, exp_q.size());
    end
  endtask

  task automatic test_pe_stall();
    push_frame(); start_frame();
    for (int i = 0; i < int'(NA); i++) serve_angle(i, (i == 1) ? 20 : 0, 1'b0, 1'b0, i == int'(NA) - 1);
  endtask

  task automatic test_spurious();
    push_frame(); start_frame();
    for (int i = 0; i < int'(NA); i++) serve_angle(i, 0, i == 0, 1'b0, i == int'(NA) - 1);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %0b expected 1", err);
    end
  endtask

  task automatic test_start_ignored();
    int d0;
    push_frame(); start_frame();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared_by_start: got %0b expected 0", err);
    end
    d0 = done_cnt;
    for (int i = 0; i < int'(NA); i++) serve_angle(i, 0, 1'b0, i == 2, i == int'(NA) - 1);
    tick(3);
    n_checks++;
    if (err !== 1'b0 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_while_busy: got err=%0b dones=%0d busy=%0b expected 0 1 0",
                         err, done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    push_frame(); start_frame();
    serve_angle(0, 0, 1'b0, 1'b0, 1'b0);
    wait_fill(cyc);
    tick(5);
    sh_fill_done = 1'b1; tick(); sh_fill_done = 1'b0;
    wait_shift(cyc);
    tick(3);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    n_checks++;
    if ({busy, done, err, sh_fill_kick, sh_shift_kick} !== 5'b0 ||
        angle_idx !== '0 || rom_addr !== '0 || sh_accu_base !== '0) begin
      n_fail++; $display("FAIL reset_mid_frame: got flags=%b idx=%0d base=%h expected all 0",
                         {busy, done, err, sh_fill_kick, sh_shift_kick}, angle_idx, sh_accu_base);
    end
    exp_q.delete();
    tick(2);
    push_frame(); start_frame();
    for (int i = 0; i < int'(NA); i++) serve_angle(i, 0, 1'b0, 1'b0, i == int'(NA) - 1);
  endtask

  task automatic test_single_angle();
    int cyc;
    start_1 = 1'b1; tick(); start_1 = 1'b0;
    cyc = 0;
    while (fill_kick_1 !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    n_checks++;
    if (cyc !== 2 || accu_base_1 !== 16'h1000 || angle_idx_1 !== 1'b0) begin
      n_fail++; $display("FAIL single_fill_kick: got lat=%0d base=%h idx=%0d expected 2 1000 0",
                         cyc, accu_base_1, angle_idx_1);
    end
    tick(5);
    fill_done_1 = 1'b1; tick(); fill_done_1 = 1'b0;
    cyc = 0;
    while (shift_kick_1 !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    n_checks++;
    if (cyc !== 1) begin
      n_fail++; $display("FAIL single_shift_kick: got lat=%0d expected 1", cyc);
    end
    tick(8);
    shift_done_1 = 1'b1; tick(); shift_done_1 = 1'b0;
    n_checks++;
    if (done_1 !== 1'b1) begin
      n_fail++; $display("FAIL single_done: got %0b expected 1", done_1);
    end
    tick(5);
    n_checks++;
    if (fill_cnt_1 !== 1 || shift_cnt_1 !== 1 || busy_1 !== 1'b0 || err_1 !== 1'b0) begin
      n_fail++; $display("FAIL single_counts: got fill=%0d shift=%0d busy=%0b err=%0b expected 1 1 0 0",
                         fill_cnt_1, shift_cnt_1, busy_1, err_1);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sh_fill_done = 1'b0; sh_shift_done = 1'b0; pe_ready = 1'b1;
    start_1 = 1'b0; fill_done_1 = 1'b0; shift_done_1 = 1'b0; pe_ready_1 = 1'b1;
    test_reset();
    test_nominal();
    test_pe_stall();
    test_spurious();
    test_start_ignored();
    test_reset_mid_frame();
    test_single_angle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
